// File: rtl/and_stim_gen.sv
// -----------------------------------------------------------------------------
// and_stim_gen
//   Stimulus source for a registered two-input AND stage. Drives the stage's
//   a/b inputs through the vectors 00, 01, 10, 11, holding each vector for a
//   programmable number of cycles and repeating the sequence a programmable
//   number of loops. A start/busy/done handshake lets a controller sequence
//   runs. After the last vector, a few flush cycles with a=b=0 let the
//   downstream pipeline drain.
//
//   Optional feature macro: AND_STIM_CHECKER_EN
//     When defined, an in-line checker compares the AND stage's returned c
//     against the expected AND, one cycle late.
//     When undefined, the checker ports and logic are absent.
//
// Parameters
//   HOLD_W  width of i_hold_cycles (0 is treated as 1)
//   LOOP_W  width of i_num_loops   (0 is treated as 1)
//   FLUSH   idle cycles (a=b=0, busy=1) after the last vector
//
// Ports
//   i_clk          clock; all logic on posedge
//   i_reset_n      synchronous active-low reset
//   i_start        run request, only honoured in IDLE
//   i_hold_cycles  cycles per vector, latched when start is accepted
//   i_num_loops    loops per run, latched when start is accepted
//   o_a / o_b      registered stimulus bits (vector MSB / LSB)
//   o_busy         high during DRIVE and FLUSH
//   o_done         one-cycle pulse at the end of a run
//   i_c_in         [checker] c returned from the AND stage
//   o_err          [checker] one-cycle pulse per mismatch
//   o_err_count    [checker] saturating mismatch count
// -----------------------------------------------------------------------------
module and_stim_gen #(
    parameter int HOLD_W = 8,
    parameter int LOOP_W = 8,
    parameter int FLUSH  = 2
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_start,
    input  logic [HOLD_W-1:0] i_hold_cycles,
    input  logic [LOOP_W-1:0] i_num_loops,
    output logic              o_a,
    output logic              o_b,
    output logic              o_busy,
`ifdef AND_STIM_CHECKER_EN
    input  logic              i_c_in,
    output logic              o_err,
    output logic [7:0]        o_err_count,
`endif
    output logic              o_done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam bit FLUSH_EN = (FLUSH > 0);
    localparam int FL_W     = (FLUSH > 1) ? $clog2(FLUSH) : 1;
    localparam logic [FL_W-1:0]   FL_LAST  = FL_W'(FLUSH_EN ? (FLUSH - 1) : 0);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1'b1);
    localparam logic [LOOP_W-1:0] LOOP_ONE = LOOP_W'(1'b1);

    state_t            r_state;
    logic [HOLD_W-1:0] r_hold_lat;
    logic [LOOP_W-1:0] r_loop_lat;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [LOOP_W-1:0] r_loop_cnt;
    logic [1:0]        r_idx;
    logic [FL_W-1:0]   r_flush_cnt;
    logic              r_a;
    logic              r_b;
    logic              r_busy;
    logic              r_done;

    logic              w_start_acc;
    logic [HOLD_W-1:0] w_hold_eff;
    logic [LOOP_W-1:0] w_loop_eff;
    logic              w_hold_last;
    logic              w_vec_last;
    logic              w_loop_last;

    assign w_start_acc = (r_state == ST_IDLE) && i_start;

    // Zero hold/loop requests are promoted to 1 so every run drives all vectors.
    assign w_hold_eff  = (i_hold_cycles == {HOLD_W{1'b0}}) ? HOLD_ONE : i_hold_cycles;
    assign w_loop_eff  = (i_num_loops   == {LOOP_W{1'b0}}) ? LOOP_ONE : i_num_loops;

    // Terminal-count compares use latched value minus one, so all-ones
    // settings count to the top without needing a wider counter.
    assign w_hold_last = (r_hold_cnt == (r_hold_lat - HOLD_ONE));
    assign w_vec_last  = (r_idx == 2'd3);
    assign w_loop_last = (r_loop_cnt == (r_loop_lat - LOOP_ONE));

    assign o_a    = r_a;
    assign o_b    = r_b;
    assign o_busy = r_busy;
    assign o_done = r_done;

    // Run sequencer: state, counters and all registered stimulus outputs.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state     <= ST_IDLE;
            r_hold_lat  <= {HOLD_W{1'b0}};
            r_loop_lat  <= {LOOP_W{1'b0}};
            r_hold_cnt  <= {HOLD_W{1'b0}};
            r_loop_cnt  <= {LOOP_W{1'b0}};
            r_idx       <= 2'd0;
            r_flush_cnt <= {FL_W{1'b0}};
            r_a         <= 1'b0;
            r_b         <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    r_a    <= 1'b0;
                    r_b    <= 1'b0;
                    if (w_start_acc) begin
                        // Vector 00 and busy appear together on the next cycle.
                        r_state    <= ST_DRIVE;
                        r_hold_lat <= w_hold_eff;
                        r_loop_lat <= w_loop_eff;
                        r_hold_cnt <= {HOLD_W{1'b0}};
                        r_loop_cnt <= {LOOP_W{1'b0}};
                        r_idx      <= 2'd0;
                        r_busy     <= 1'b1;
                    end else begin
                        r_busy <= 1'b0;
                    end
                end

                ST_DRIVE: begin
                    if (w_hold_last) begin
                        r_hold_cnt <= {HOLD_W{1'b0}};
                        if (w_vec_last) begin
                            r_idx <= 2'd0;
                            r_a   <= 1'b0;
                            r_b   <= 1'b0;
                            if (w_loop_last) begin
                                r_loop_cnt <= {LOOP_W{1'b0}};
                                if (FLUSH_EN) begin
                                    r_state     <= ST_FLUSH;
                                    r_flush_cnt <= {FL_W{1'b0}};
                                end else begin
                                    r_state <= ST_DONE;
                                    r_busy  <= 1'b0;
                                    r_done  <= 1'b1;
                                end
                            end else begin
                                r_loop_cnt <= r_loop_cnt + LOOP_ONE;
                            end
                        end else begin
                            // Outputs take the next index directly so a/b stay registered.
                            r_idx <= r_idx + 2'd1;
                            {r_a, r_b} <= r_idx + 2'd1;
                        end
                    end else begin
                        r_hold_cnt <= r_hold_cnt + HOLD_ONE;
                    end
                end

                ST_FLUSH: begin
                    r_a <= 1'b0;
                    r_b <= 1'b0;
                    if (r_flush_cnt == FL_LAST) begin
                        r_state     <= ST_DONE;
                        r_flush_cnt <= {FL_W{1'b0}};
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                    end else begin
                        r_flush_cnt <= r_flush_cnt + FL_W'(1'b1);
                    end
                end

                ST_DONE: begin
                    // Start is ignored here; the earliest new run is the next IDLE cycle.
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_a     <= 1'b0;
                    r_b     <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

`ifdef AND_STIM_CHECKER_EN
    logic       r_exp;
    logic       r_chk_vld;
    logic       r_err;
    logic [7:0] r_err_count;
    logic       w_mismatch;

    // The AND stage registers its inputs, so its c lags a/b by one cycle;
    // r_exp and r_chk_vld are delayed by the same amount.
    assign w_mismatch  = r_chk_vld && (i_c_in != r_exp);
    assign o_err       = r_err;
    assign o_err_count = r_err_count;

    // In-line checker: expected-value pipeline, error pulse and saturating count.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_exp       <= 1'b0;
            r_chk_vld   <= 1'b0;
            r_err       <= 1'b0;
            r_err_count <= 8'd0;
        end else begin
            r_exp     <= r_a & r_b;
            r_chk_vld <= (r_state == ST_DRIVE) || (r_state == ST_FLUSH);
            r_err     <= w_mismatch;
            if (w_start_acc) begin
                r_err_count <= 8'd0;
            end else if (w_mismatch && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end else begin
                r_err_count <= r_err_count;
            end
        end
    end
`endif

endmodule

// File: tb/tb_and_stim_gen.sv
// -----------------------------------------------------------------------------
// tb_and_stim_gen
//   Self-checking bench for and_stim_gen. Expected per-cycle {a,b,busy,done}
//   values are pushed to a scoreboard queue when a run is started and popped
//   and compared on each falling edge. Checker scenarios are built only when
//   AND_STIM_CHECKER_EN is defined.
// -----------------------------------------------------------------------------
module tb_and_stim_gen;

    localparam int FLUSH = 2;

    logic       i_clk = 1'b0;
    logic       i_reset_n;
    logic       i_start;
    logic [7:0] i_hold_cycles;
    logic [7:0] i_num_loops;
    logic       o_a;
    logic       o_b;
    logic       o_busy;
    logic       o_done;

    int total = 0;
    int bad   = 0;

    logic [3:0] sb_q[$];

    always #5 i_clk = ~i_clk;

`ifdef AND_STIM_CHECKER_EN
    logic       i_c_in;
    logic       o_err;
    logic [7:0] o_err_count;
    logic       r_and = 1'b0;
    logic       tie_c = 1'b0;

    // Model of the registered AND stage feeding c back to the checker.
    always @(posedge i_clk) r_and <= o_a & o_b;
    assign i_c_in = tie_c ? 1'b1 : r_and;
`endif

    and_stim_gen dut (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_start       (i_start),
        .i_hold_cycles (i_hold_cycles),
        .i_num_loops   (i_num_loops),
        .o_a           (o_a),
        .o_b           (o_b),
        .o_busy        (o_busy),
`ifdef AND_STIM_CHECKER_EN
        .i_c_in        (i_c_in),
        .o_err         (o_err),
        .o_err_count   (o_err_count),
`endif
        .o_done        (o_done)
    );

    // Expected cycles of one run starting the cycle after start is accepted.
    task automatic push_run(input int hh, input int ll);
        logic [1:0] vv;
        for (int lp = 0; lp < ll; lp++) begin
            for (int v = 0; v < 4; v++) begin
                vv = v[1:0];
                for (int c = 0; c < hh; c++) sb_q.push_back({vv, 2'b10});
            end
        end
        for (int f = 0; f < FLUSH; f++) sb_q.push_back(4'b0010);
        sb_q.push_back(4'b0001);
    endtask

    task automatic run_check(input string name, input logic [7:0] h, input logic [7:0] l,
                             input bit disturb, output int busy_seen, output int err_seen);
        int hh;
        int ll;
        int n;
        logic [3:0] exp_v;
        logic [3:0] got_v;
        hh = (h == 8'd0) ? 1 : int'(h);
        ll = (l == 8'd0) ? 1 : int'(l);
        busy_seen = 0;
        err_seen  = 0;
        n = 0;
        push_run(hh, ll);
        sb_q.push_back(4'b0000);
        sb_q.push_back(4'b0000);
        i_hold_cycles = h;
        i_num_loops   = l;
        i_start       = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        while (sb_q.size() > 0) begin
            @(negedge i_clk);
            exp_v = sb_q.pop_front();
            got_v = {o_a, o_b, o_busy, o_done};
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL %s cycle %0d: abbd got=%b expected=%b", name, n, got_v, exp_v);
            end
            if (o_busy === 1'b1) busy_seen++;
`ifdef AND_STIM_CHECKER_EN
            if (o_err === 1'b1) err_seen++;
`endif
            if (disturb) begin
                // Poke start and new settings mid-run and during the done cycle.
                if (n == 2 || exp_v == 4'b0001) begin
                    i_start       = 1'b1;
                    i_hold_cycles = h + 8'd3;
                    i_num_loops   = l + 8'd1;
                end else begin
                    i_start = 1'b0;
                end
            end
            n++;
        end
        i_start = 1'b0;
    endtask

    task automatic test_reset();
        int seen;
        i_reset_n = 1'b0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        total++;
        if ({o_a, o_b, o_busy, o_done} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_init: abbd got=%b expected=0000", {o_a, o_b, o_busy, o_done});
        end
        i_reset_n = 1'b1;
        @(negedge i_clk);
        // Start a long run and abandon it with reset.
        i_hold_cycles = 8'd2;
        i_num_loops   = 8'd2;
        i_start       = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        repeat (5) @(negedge i_clk);
        total++;
        if (o_busy !== 1'b1) begin
            bad++;
            $display("FAIL reset_prerun_busy: got=%b expected=1", o_busy);
        end
        i_reset_n = 1'b0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        total++;
        if ({o_a, o_b, o_busy, o_done} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_midrun: abbd got=%b expected=0000", {o_a, o_b, o_busy, o_done});
        end
`ifdef AND_STIM_CHECKER_EN
        total++;
        if (o_err_count !== 8'd0 || o_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_chk: err=%b count=%0d expected 0/0", o_err, o_err_count);
        end
`endif
        i_reset_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge i_clk);
            if (o_done !== 1'b0 || o_busy !== 1'b0) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL reset_no_done: active cycles got=%0d expected=0", seen);
        end
    endtask

    task automatic test_basic();
        int bs;
        int es;
        run_check("h1_l1", 8'd1, 8'd1, 1'b0, bs, es);
        total++;
        if (bs != 6) begin
            bad++;
            $display("FAIL h1_l1_busy: got=%0d expected=6", bs);
        end
    endtask

    task automatic test_zero_and_multi();
        int bs;
        int es;
        run_check("h0_l0", 8'd0, 8'd0, 1'b0, bs, es);
        total++;
        if (bs != 6) begin
            bad++;
            $display("FAIL h0_l0_busy: got=%0d expected=6", bs);
        end
        run_check("h3_l2", 8'd3, 8'd2, 1'b0, bs, es);
        total++;
        if (bs != 26) begin
            bad++;
            $display("FAIL h3_l2_busy: got=%0d expected=26", bs);
        end
    endtask

    task automatic test_ignore_start();
        int bs;
        int es;
        run_check("disturb", 8'd2, 8'd1, 1'b1, bs, es);
        total++;
        if (bs != 4 * 2 * 1 + FLUSH) begin
            bad++;
            $display("FAIL disturb_busy: got=%0d expected=%0d", bs, 4 * 2 * 1 + FLUSH);
        end
    endtask

    task automatic test_max();
        int bs;
        int es;
        run_check("hold_max", 8'hFF, 8'd1, 1'b0, bs, es);
        total++;
        if (bs != 4 * 255 + FLUSH) begin
            bad++;
            $display("FAIL hold_max_busy: got=%0d expected=%0d", bs, 4 * 255 + FLUSH);
        end
        run_check("loop_max", 8'd1, 8'hFF, 1'b0, bs, es);
        total++;
        if (bs != 4 * 255 + FLUSH) begin
            bad++;
            $display("FAIL loop_max_busy: got=%0d expected=%0d", bs, 4 * 255 + FLUSH);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        logic [3:0] exp_v;
        logic [3:0] got_v;
        // Run 1 (H=1) takes 7 cycles incl. done, one idle cycle, then run 2 (H=2).
        push_run(1, 1);
        sb_q.push_back(4'b0000);
        push_run(2, 1);
        sb_q.push_back(4'b0000);
        sb_q.push_back(4'b0000);
        n = 0;
        i_hold_cycles = 8'd1;
        i_num_loops   = 8'd1;
        i_start       = 1'b1;
        @(posedge i_clk);
        #1;
        while (sb_q.size() > 0) begin
            @(negedge i_clk);
            exp_v = sb_q.pop_front();
            got_v = {o_a, o_b, o_busy, o_done};
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL back_to_back cycle %0d: abbd got=%b expected=%b", n, got_v, exp_v);
            end
            if (n == 7) i_hold_cycles = 8'd2;
            if (n == 8) i_start = 1'b0;
            n++;
        end
        i_start = 1'b0;
    endtask

`ifdef AND_STIM_CHECKER_EN
    task automatic test_checker_clean();
        int bs;
        int es;
        tie_c = 1'b0;
        run_check("chk_clean", 8'd2, 8'd3, 1'b0, bs, es);
        total++;
        if (es != 0 || o_err_count !== 8'd0) begin
            bad++;
            $display("FAIL chk_clean: err pulses=%0d count=%0d expected 0/0", es, o_err_count);
        end
        total++;
        if (bs != 26) begin
            bad++;
            $display("FAIL chk_clean_busy: got=%0d expected=26", bs);
        end
    endtask

    task automatic test_checker_tied();
        int bs;
        int es;
        int w;
        tie_c = 1'b1;
        run_check("chk_tied", 8'd1, 8'd1, 1'b0, bs, es);
        total++;
        if (es != 5) begin
            bad++;
            $display("FAIL chk_tied_pulses: got=%0d expected=5", es);
        end
        total++;
        if (o_err_count !== 8'd5) begin
            bad++;
            $display("FAIL chk_tied_count: got=%0d expected=5", o_err_count);
        end
        i_start = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        @(negedge i_clk);
        total++;
        if (o_err_count !== 8'd0) begin
            bad++;
            $display("FAIL chk_clear_on_start: got=%0d expected=0", o_err_count);
        end
        w = 0;
        while (o_done !== 1'b1 && w < 50) begin
            @(negedge i_clk);
            w++;
        end
        if (w >= 50) begin
            total++;
            bad++;
            $display("FAIL chk_rerun_timeout: waited=%0d cycles for done", w);
        end
        repeat (2) @(negedge i_clk);
        tie_c = 1'b0;
    endtask
`endif

    initial begin
        i_reset_n     = 1'b0;
        i_start       = 1'b0;
        i_hold_cycles = 8'd0;
        i_num_loops   = 8'd0;
        test_reset();
        test_basic();
        test_zero_and_multi();
        test_ignore_start();
        test_back_to_back();
        test_max();
`ifdef AND_STIM_CHECKER_EN
        test_checker_clean();
        test_checker_tied();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
